// File: rtl/act_skew_feeder.sv
// -----------------------------------------------------------------------------
// act_skew_feeder
//
// Feeds activation vectors into the west edge of a systolic array.
// Incoming vectors are buffered in a small FIFO. Each popped vector is skewed
// so that lane r reaches row r exactly r+1 cycles after the pop. After the
// last vector of a tile, the feeder flushes the skew chains with 2*N-1 bubble
// cycles and then pulses o_tile_done. While i_hold is high the array is busy
// loading weights, so everything downstream of the FIFO write side freezes.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   in_data      N*8  activation vector, lane r = bits [8r+7:8r]
//   in_valid     in_data/in_last valid
//   in_last      final vector of a tile
//   in_ready     FIFO can accept (not full, low during reset)
//   i_hold       freeze feeder (array loading weights)
//   o_west       N*8  skewed activations, lane r -> row r, column 0
//   o_row_valid  N    lane r of o_west carries real data
//   o_busy       anything queued, in flight or flushing
//   o_tile_done  one-cycle pulse when a tile's flush completes
// -----------------------------------------------------------------------------
module act_skew_feeder #(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*8-1:0] in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    input  logic           i_hold,
    output logic [N*8-1:0] o_west,
    output logic [N-1:0]   o_row_valid,
    output logic           o_busy,
    output logic           o_tile_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    state_t          state;
    logic [CW-1:0]   flush_cnt;

    // -------------------------------------------------------------------------
    // Input FIFO: {last, data} per entry; pointers carry one wrap bit.
    // -------------------------------------------------------------------------
    logic [N*8:0]    mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [N*8:0]    head;
    logic [N*8-1:0]  head_data;
    logic            head_last;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // No bypass: a pop in the same cycle does not make room for a push.
    assign in_ready  = !reset && !full;
    assign push      = in_valid && in_ready;
    // The FIFO is never drained during a flush, so the next tile waits.
    assign pop       = (state != FLUSH) && !i_hold && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_data = head[N*8-1:0];
    assign head_last = head[N*8];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tile FSM with flush counter; o_tile_done is registered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            o_tile_done <= 1'b0;
        end else begin
            o_tile_done <= 1'b0;
            if (!i_hold) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            if (head_last) begin
                                state     <= FLUSH;
                                flush_cnt <= FLUSH_LOAD;
                            end else begin
                                state <= STREAM;
                            end
                        end
                    end
                    STREAM: begin
                        if (pop && head_last) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == CW'(1)) begin
                            state       <= IDLE;
                            flush_cnt   <= '0;
                            o_tile_done <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Skew chains: lane r is a shift register of r+1 byte stages. New data
    // enters the low byte; the top byte drives the array. Non-pop cycles
    // shift in a zero bubble with valid low.
    // -------------------------------------------------------------------------
    logic [N-1:0] lane_busy;

    for (genvar r = 0; r < N; r++) begin : g_lane
        localparam int LW = r + 1;
        localparam int DW = 8 * LW;

        logic [DW-1:0] dat;
        logic [LW-1:0] vld;
        logic [7:0]    nb;

        assign nb = pop ? head_data[8*r +: 8] : 8'h00;

        always_ff @(posedge clk) begin
            if (reset) begin
                dat <= '0;
                vld <= '0;
            end else if (!i_hold) begin
                dat <= DW'({dat, nb});
                vld <= LW'({vld, pop});
            end
        end

        assign o_west[8*r +: 8] = dat[8*r +: 8];
        assign o_row_valid[r]   = vld[r];
        assign lane_busy[r]     = |vld;
    end

    assign o_busy = (state != IDLE) || !empty || (|lane_busy);

endmodule

// File: tb/tb_act_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_act_skew_feeder
//
// Directed bench for act_skew_feeder (N=4, DEPTH=8). The stimulus process
// pushes vectors and records the expected per-lane bytes (with the expected
// arrival cycle where it is fixed) and expected tile_done pulses. A monitor
// on the falling edge pops and compares whenever the DUT presents a valid
// lane or a tile_done, and checks that outputs stay frozen across held edges.
// -----------------------------------------------------------------------------
module tb_act_skew_feeder;

    localparam int N     = 4;
    localparam int DEPTH = 8;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [31:0]   in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic          i_hold   = 1'b0;
    logic          in_ready;
    logic [31:0]   o_west;
    logic [3:0]    o_row_valid;
    logic          o_busy;
    logic          o_tile_done;

    act_skew_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .i_hold     (i_hold),
        .o_west     (o_west),
        .o_row_valid(o_row_valid),
        .o_busy     (o_busy),
        .o_tile_done(o_tile_done)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic adv = 1'b1;   // outputs were allowed to change at the last edge

    always @(posedge clk) begin
        cyc <= cyc + 1;
        adv <= reset || !i_hold;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: per-lane ring of expected bytes and arrival cycles (-1 = any)
    logic [7:0] exp_d [4][64];
    int         exp_c [4][64];
    int         head  [4] = '{default: 0};
    int         tail  [4] = '{default: 0};
    int         done_q[$];

    function automatic bit sb_empty();
        bit e = 1'b1;
        for (int r = 0; r < 4; r++) begin
            if (head[r] != tail[r]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic expect_vec(input logic [31:0] d, input int base);
        for (int r = 0; r < 4; r++) begin
            exp_d[r][tail[r]] = d[8*r +: 8];
            exp_c[r][tail[r]] = (base < 0) ? -1 : base + r;
            tail[r]++;
        end
    endtask

    // Monitor
    logic [31:0] prev_west = '0;
    logic [3:0]  prev_vld  = '0;

    always @(negedge clk) begin
        int e;
        if (adv) begin
            for (int r = 0; r < 4; r++) begin
                if (o_row_valid[r]) begin
                    if (head[r] == tail[r]) begin
                        chk($sformatf("unexpected_lane%0d_valid", r), 1, 0);
                    end else begin
                        chk($sformatf("lane%0d_data", r), 64'(o_west[8*r +: 8]), 64'(exp_d[r][head[r]]));
                        if (exp_c[r][head[r]] >= 0) begin
                            chk($sformatf("lane%0d_cycle", r), 64'(cyc), 64'(exp_c[r][head[r]]));
                        end
                        head[r]++;
                    end
                end else begin
                    chk($sformatf("lane%0d_bubble_zero", r), 64'(o_west[8*r +: 8]), 0);
                end
            end
            if (o_tile_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_tile_done", 1, 0);
                end else begin
                    e = done_q.pop_front();
                    if (e >= 0) chk("tile_done_cycle", 64'(cyc), 64'(e));
                end
            end
        end else begin
            chk("hold_west_frozen",  64'(o_west), 64'(prev_west));
            chk("hold_valid_frozen", 64'(o_row_valid), 64'(prev_vld));
            chk("hold_no_tile_done", 64'(o_tile_done), 0);
        end
        prev_west = o_west;
        prev_vld  = o_row_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic last, output int k);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        k        = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!o_busy && sb_empty() && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 64'(ok), 1);
    endtask

    task automatic single_tile(input logic [31:0] d, input string name);
        int k;
        push(d, 1'b1, k);
        expect_vec(d, k + 1);
        done_q.push_back(k + 8);
        wait_idle(name);
        chk({name, "_busy_low"}, 64'(o_busy), 0);
    endtask

    initial begin
        int k;
        logic [31:0] d;

        // Reset state
        repeat (3) tick();
        chk("ready_low_in_reset", 64'(in_ready), 0);
        reset = 1'b0;
        tick();
        chk("rst_west",      64'(o_west), 0);
        chk("rst_row_valid", 64'(o_row_valid), 0);
        chk("rst_busy",      64'(o_busy), 0);
        chk("rst_tile_done", 64'(o_tile_done), 0);
        chk("rst_ready",     64'(in_ready), 1);

        // Single vector tile
        single_tile(32'h04030201, "single");

        // Full FIFO under hold, then release
        i_hold = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ready_before_fill", 64'(in_ready), 1);
            push({8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i), 8'(i)}, (i == 8), k);
        end
        chk("full_ready_low", 64'(in_ready), 0);
        chk("full_busy",      64'(o_busy), 1);
        in_data  = 32'hEEEEEE09;
        in_last  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        chk("ninth_rejected_ready", 64'(in_ready), 0);
        k = cyc;
        for (int i = 1; i <= 8; i++) begin
            expect_vec({8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i), 8'(i)}, k + i);
        end
        done_q.push_back(k + 15);
        i_hold = 1'b0;
        wait_idle("full_drain");

        // Hold mid-stream for three edges
        expect_vec(32'hA4A3A2A1, -1);
        expect_vec(32'hB4B3B2B1, -1);
        expect_vec(32'hC4C3C2C1, -1);
        expect_vec(32'hD4D3D2D1, -1);
        expect_vec(32'hE4E3E2E1, -1);
        done_q.push_back(-1);
        push(32'hA4A3A2A1, 1'b0, k);
        push(32'hB4B3B2B1, 1'b0, k);
        push(32'hC4C3C2C1, 1'b0, k);
        i_hold = 1'b1;
        push(32'hD4D3D2D1, 1'b0, k);
        push(32'hE4E3E2E1, 1'b1, k);
        tick();
        i_hold = 1'b0;
        wait_idle("hold_drain");

        // Bubble between two vectors of one tile
        push(32'h5A5A5A5A, 1'b0, k);
        expect_vec(32'h5A5A5A5A, k + 1);
        tick();
        tick();
        push(32'h6B6B6B6B, 1'b1, k);
        expect_vec(32'h6B6B6B6B, k + 1);
        done_q.push_back(k + 8);
        wait_idle("bubble_drain");

        // Reset while flushing (counter at 3)
        d = 32'h0D0C0B0A;
        push(d, 1'b1, k);
        expect_vec(d, k + 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("flushrst_ready_low", 64'(in_ready), 0);
        chk("flushrst_west",      64'(o_west), 0);
        chk("flushrst_valid",     64'(o_row_valid), 0);
        chk("flushrst_busy",      64'(o_busy), 0);
        chk("flushrst_tile_done", 64'(o_tile_done), 0);
        reset = 1'b0;
        tick();
        chk("flushrst_ready_back", 64'(in_ready), 1);
        single_tile(32'h44332211, "after_reset");

        // Back-to-back tiles
        push(32'h71717171, 1'b0, k);
        expect_vec(32'h71717171, k + 1);
        expect_vec(32'h72727272, k + 2);
        expect_vec(32'h81818181, k + 10);
        done_q.push_back(k + 9);
        done_q.push_back(k + 17);
        push(32'h72727272, 1'b1, k);
        push(32'h81818181, 1'b1, k);
        wait_idle("b2b_drain");

        chk("scoreboard_empty", 64'(sb_empty()), 1);
        chk("tile_done_queue_empty", 64'(done_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter N, default 4: number of array rows fed (one 8-bit lane per row).
REQ-002 Parameter DEPTH, default 8, power of two: input FIFO depth in vectors.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  N*8  activation vector; lane r = bits [8r+7:8r] is destined for row r.
REQ-006 in_valid  input  1  in_data/in_last valid.
REQ-007 in_last  input  1  marks final vector of a tile.
REQ-008 in_ready  output  1  FIFO can accept; equals !full, 0 while reset is asserted.
REQ-009 i_hold  input  1  array is loading weights; feeder freezes.
REQ-010 o_west  output  N*8  skewed activations; lane r drives the west input of row r, column 0.
REQ-011 o_row_valid  output  N  bit r high when lane r of o_west carries real data.
REQ-012 o_busy  output  1  high while any vector is queued, in flight or flushing.
REQ-013 o_tile_done  output  1  single-cycle pulse when a tile's flush completes.

Function
REQ-014 Push occurs on in_valid && in_ready, including while i_hold=1; a push and pop in the same cycle are both performed.
REQ-015 in_ready SHALL be !full only; no same-cycle bypass when full, even if a pop occurs.
REQ-016 FSM states: IDLE, STREAM, FLUSH.
REQ-017 Pop condition: state IDLE or STREAM, i_hold=0, FIFO non-empty.
REQ-018 On pop, the vector is issued: lane r enters a delay chain of r+1 registers; o_west lane r = element r, o_row_valid[r]=1, exactly r+1 cycles after the pop edge.
REQ-019 Non-pop, non-hold cycle: zeros issued with valid 0 into every chain (bubble).
REQ-020 IDLE: pop of non-last -> STREAM; pop of last -> FLUSH; empty -> stay IDLE.
REQ-021 STREAM: pop of last -> FLUSH; pop of non-last or empty FIFO (bubble) -> stay STREAM.
REQ-022 On entering FLUSH, the flush counter loads 2*N-1; each non-hold FLUSH cycle issues zeros (valid 0) and decrements.
REQ-023 FLUSH with counter==1 and i_hold=0 -> IDLE, o_tile_done registered high for exactly the next cycle.
REQ-024 FIFO is not popped in FLUSH; vectors of the next tile wait in the FIFO.
REQ-025 i_hold=1 freezes the FSM, flush counter, FIFO read pointer and all delay chains; o_west/o_row_valid hold their values; o_tile_done is never asserted during hold.
REQ-026 o_busy = (state!=IDLE) || FIFO non-empty || any delay-chain valid bit set.
REQ-027 Data is passed unmodified; no arithmetic on lanes.

Reset
REQ-028 Reset empties the FIFO, sets state IDLE, clears the flush counter and all delay-chain data and valid bits.
REQ-029 Reset values: o_west=0, o_row_valid=0, o_busy=0, o_tile_done=0; in_ready=1 on the first cycle after reset deasserts.
REQ-030 Reset mid-tile/mid-flush discards all queued and in-flight data; no o_tile_done is produced for the aborted tile.

Verification
REQ-031 Single vector: push in_data=0x04030201, in_last=1, i_hold=0 -> row0=0x01 one cycle after pop, row1=0x02 at +2, row2=0x03 at +3, row3=0x04 at +4, each with valid for one cycle; o_tile_done pulses 7 cycles after row0 data; o_busy then 0.
REQ-032 Full FIFO: i_hold=1, push 8 vectors 0x..01..0x..08 -> in_ready=0 after the 8th, 9th not accepted; release hold -> row0 shows 01..08 on 8 consecutive cycles.
REQ-033 Hold mid-stream: assert i_hold 3 cycles while streaming -> o_west, o_row_valid and FSM frozen 3 cycles, sequence resumes unchanged with no loss or duplication.
REQ-034 Bubble: push vector A (non-last), gap 2 cycles, push B last -> row0 shows A, 0 (valid 0) x2, B; single tile_done after B's flush.
REQ-035 Reset in FLUSH (counter=3) -> next cycle all outputs 0, state IDLE, no tile_done; new tile behaves as REQ-031.
REQ-036 Back-to-back tiles: queue tile1 (2 vectors, last on 2nd) and tile2 (1 vector) -> tile2 pop occurs only after tile1's tile_done cycle; two tile_done pulses total.
